intr_sequencer: RTL and testbench

INTR_SEQUENCER -- requirements
Module: intr_sequencer

---
 rtl/intr_sequencer_if.sv | 38 +++
 rtl/intr_sequencer.sv | 121 ++++++++++++
 tb/tb_intr_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_sequencer_if
// Purpose  : Request/response signal bundle between the interrupt sequencer,
//            the interrupt controller and the pipeline front end.
// Revision : 1.0  initial release
// ============================================================================
interface intr_sequencer_if;
    logic        I_intr;
    logic [1:0]  I_intr_vector;
    logic [31:0] I_pc;
    logic        I_stall;
    logic        I_branch_pending;
    logic        I_reti;
    logic        I_ie_set;
    logic        I_ie_clr;
    logic        O_intr_ack;
    logic        O_redirect;
    logic [31:0] O_redirect_pc;
    logic [31:0] O_epc;
    logic        O_in_isr;
    logic        O_ie;

    // Driver side: controller / pipeline / bench
    modport master (
        output I_intr, I_intr_vector, I_pc, I_stall, I_branch_pending,
               I_reti, I_ie_set, I_ie_clr,
        input  O_intr_ack, O_redirect, O_redirect_pc, O_epc, O_in_isr, O_ie
    );

    // Sequencer side
    modport slave (
        input  I_intr, I_intr_vector, I_pc, I_stall, I_branch_pending,
               I_reti, I_ie_set, I_ie_clr,
        output O_intr_ack, O_redirect, O_redirect_pc, O_epc, O_in_isr, O_ie
    );
endinterface
`default_nettype wire

// File: rtl/intr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : intr_sequencer
// Purpose  : Takes an interrupt at a safe pipeline point, redirects fetch to
//            the vector handler, and returns to the saved PC on reti.
// Revision : 1.0  initial release
// ============================================================================
module intr_sequencer #(
    parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
    parameter int          VECTOR_SHIFT = 4
) (
    input  wire logic      I_clk,
    input  wire logic      I_rst,
    intr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SAFE = 2'd1,
        ISR       = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  vector_q, vector_d;
    logic        intr_ack_q, intr_ack_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] epc_q, epc_d;
    logic        in_isr_q, in_isr_d;
    logic        ie_q, ie_d;
    logic [31:0] handler_pc;

    // Slot offset wraps modulo 2^32 with the base address.
    assign handler_pc = VECTOR_BASE + (32'(vector_q) << VECTOR_SHIFT);

    always_comb begin
        state_d       = state_q;
        vector_d      = vector_q;
        intr_ack_d    = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        epc_d         = epc_q;
        in_isr_d      = in_isr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.I_intr && ie_q) begin
                    if (bus.I_intr_vector == 2'd0) begin
                        intr_ack_d = 1'b1;
                    end else begin
                        vector_d = bus.I_intr_vector;
                        state_d  = WAIT_SAFE;
                    end
                end
            end
            WAIT_SAFE: begin
                if (!bus.I_intr || !ie_q) begin
                    state_d = IDLE;
                end else if (!bus.I_stall && !bus.I_branch_pending) begin
                    intr_ack_d    = 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = handler_pc;
                    epc_d         = bus.I_pc;
                    in_isr_d      = 1'b1;
                    state_d       = ISR;
                end
            end
            ISR: begin
                // New requests wait until the return redirect has gone out.
                if (bus.I_reti) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = epc_q;
                    in_isr_d      = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.I_ie_clr) begin
            ie_d = 1'b0;
        end else if (bus.I_ie_set) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q       <= IDLE;
            vector_q      <= 2'd0;
            intr_ack_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            epc_q         <= 32'd0;
            in_isr_q      <= 1'b0;
            ie_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            vector_q      <= vector_d;
            intr_ack_q    <= intr_ack_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            epc_q         <= epc_d;
            in_isr_q      <= in_isr_d;
            ie_q          <= ie_d;
        end
    end

    assign bus.O_intr_ack    = intr_ack_q;
    assign bus.O_redirect    = redirect_q;
    assign bus.O_redirect_pc = redirect_pc_q;
    assign bus.O_epc         = epc_q;
    assign bus.O_in_isr      = in_isr_q;
    assign bus.O_ie          = ie_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_sequencer
// Purpose  : Directed scenarios plus randomized traffic against a
//            rule-level reference model of the interrupt sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_intr_sequencer;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          SHIFT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    intr_sequencer_if bus ();

    intr_sequencer #(
        .VECTOR_BASE  (BASE),
        .VECTOR_SHIFT (SHIFT)
    ) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the edge that produced them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.I_intr           = 1'b0;
        bus.I_intr_vector    = 2'd0;
        bus.I_stall          = 1'b0;
        bus.I_branch_pending = 1'b0;
        bus.I_reti           = 1'b0;
        bus.I_ie_set         = 1'b0;
        bus.I_ie_clr         = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        bus.I_pc = 32'h200;
        rst = 1'b1;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie});
        end
        checks++;
        if ({bus.O_redirect_pc, bus.O_epc} !== 64'd0) begin
            errors++;
            $display("FAIL reset_pcs got rpc=%h epc=%h want 0", bus.O_redirect_pc, bus.O_epc);
        end
        rst = 1'b0;
    endtask

    task automatic test_dispatch();
        quiet();
        bus.I_ie_set = 1'b1;
        step();
        bus.I_ie_set = 1'b0;
        checks++;
        if (bus.O_ie !== 1'b1) begin
            errors++;
            $display("FAIL ie_set got %b want 1", bus.O_ie);
        end
        bus.I_pc = 32'h200; bus.I_intr = 1'b1; bus.I_intr_vector = 2'd1;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect} !== 2'b00) begin
            errors++;
            $display("FAIL dispatch_early got %b want 00", {bus.O_intr_ack, bus.O_redirect});
        end
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b111 ||
            bus.O_redirect_pc !== 32'h110 || bus.O_epc !== 32'h200) begin
            errors++;
            $display("FAIL dispatch got flags=%b rpc=%h epc=%h want 111 110 200",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_redirect_pc, bus.O_epc);
        end
        bus.I_intr = 1'b0; bus.I_pc = 32'h300;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b001 || bus.O_epc !== 32'h200) begin
            errors++;
            $display("FAIL dispatch_pulse got flags=%b epc=%h want 001 200",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_epc);
        end
        bus.I_reti = 1'b1;
        step();
        bus.I_reti = 1'b0;
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b010 || bus.O_redirect_pc !== 32'h200) begin
            errors++;
            $display("FAIL return got flags=%b rpc=%h want 010 200",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_redirect_pc);
        end
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b000) begin
            errors++;
            $display("FAIL return_pulse got %b want 000", {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr});
        end
    endtask

    task automatic test_stall();
        quiet();
        bus.I_pc = 32'h200; bus.I_intr = 1'b1; bus.I_intr_vector = 2'd2; bus.I_stall = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.O_intr_ack, bus.O_redirect} !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %b want 00", i, {bus.O_intr_ack, bus.O_redirect});
            end
        end
        bus.I_stall = 1'b0;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b111 ||
            bus.O_redirect_pc !== 32'h120 || bus.O_epc !== 32'h200) begin
            errors++;
            $display("FAIL stall_release got flags=%b rpc=%h epc=%h want 111 120 200",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_redirect_pc, bus.O_epc);
        end
        bus.I_intr = 1'b0; bus.I_reti = 1'b1;
        step();
        bus.I_reti = 1'b0;
        step();
    endtask

    task automatic test_no_nesting();
        quiet();
        bus.I_pc = 32'h200; bus.I_intr = 1'b1; bus.I_intr_vector = 2'd1;
        step();
        step();
        bus.I_pc = 32'h444;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.O_intr_ack, bus.O_in_isr} !== 2'b01) begin
                errors++;
                $display("FAIL nest_ignored[%0d] got ack/isr=%b want 01", i, {bus.O_intr_ack, bus.O_in_isr});
            end
        end
        bus.I_reti = 1'b1;
        step();
        bus.I_reti = 1'b0;
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b010 || bus.O_redirect_pc !== 32'h200) begin
            errors++;
            $display("FAIL nest_return got flags=%b rpc=%h want 010 200",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_redirect_pc);
        end
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect} !== 2'b00) begin
            errors++;
            $display("FAIL nest_too_soon got %b want 00", {bus.O_intr_ack, bus.O_redirect});
        end
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b111 ||
            bus.O_redirect_pc !== 32'h110 || bus.O_epc !== 32'h444) begin
            errors++;
            $display("FAIL nest_pending got flags=%b rpc=%h epc=%h want 111 110 444",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr}, bus.O_redirect_pc, bus.O_epc);
        end
        bus.I_intr = 1'b0; bus.I_reti = 1'b1;
        step();
        bus.I_reti = 1'b1;
        step();
        bus.I_reti = 1'b0;
        checks++;
        if (bus.O_redirect !== 1'b0) begin
            errors++;
            $display("FAIL reti_outside got redirect=%b want 0", bus.O_redirect);
        end
    endtask

    task automatic test_wait_abort();
        quiet();
        bus.I_intr = 1'b1; bus.I_intr_vector = 2'd3; bus.I_branch_pending = 1'b1;
        step();
        bus.I_intr = 1'b0;
        step();
        bus.I_branch_pending = 1'b0;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop got %b want 000", {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr});
        end
        bus.I_intr = 1'b1; bus.I_stall = 1'b1;
        step();
        bus.I_ie_clr = 1'b1;
        step();
        bus.I_ie_clr = 1'b0; bus.I_stall = 1'b0;
        step();
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_ie got %b want 0000",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie});
        end
    endtask

    task automatic test_ie_disabled();
        quiet();
        bus.I_intr = 1'b1; bus.I_intr_vector = 2'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({bus.O_intr_ack, bus.O_redirect} !== 2'b00) begin
                errors++;
                $display("FAIL ie_off[%0d] got %b want 00", i, {bus.O_intr_ack, bus.O_redirect});
            end
        end
        bus.I_intr = 1'b0; bus.I_ie_set = 1'b1; bus.I_ie_clr = 1'b1;
        step();
        checks++;
        if (bus.O_ie !== 1'b0) begin
            errors++;
            $display("FAIL ie_both_from0 got %b want 0", bus.O_ie);
        end
        bus.I_ie_clr = 1'b0;
        step();
        bus.I_ie_clr = 1'b1;
        step();
        bus.I_ie_set = 1'b0; bus.I_ie_clr = 1'b0;
        checks++;
        if (bus.O_ie !== 1'b0) begin
            errors++;
            $display("FAIL ie_both_from1 got %b want 0", bus.O_ie);
        end
    endtask

    task automatic test_spurious();
        quiet();
        bus.I_ie_set = 1'b1;
        step();
        bus.I_ie_set = 1'b0; bus.I_intr = 1'b1; bus.I_intr_vector = 2'd0;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b100) begin
            errors++;
            $display("FAIL spurious got %b want 100", {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr});
        end
        bus.I_intr = 1'b0;
        step();
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_pulse got %b want 000", {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr});
        end
    endtask

    task automatic test_reset_in_isr();
        quiet();
        bus.I_pc = 32'h200; bus.I_intr = 1'b1; bus.I_intr_vector = 2'd1;
        step();
        step();
        bus.I_intr = 1'b0;
        step();
        checks++;
        if (bus.O_in_isr !== 1'b1 || bus.O_epc !== 32'h200) begin
            errors++;
            $display("FAIL rst_isr_setup got isr=%b epc=%h want 1 200", bus.O_in_isr, bus.O_epc);
        end
        rst = 1'b1; bus.I_reti = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie} !== 4'b0000 ||
            bus.O_redirect_pc !== 32'd0 || bus.O_epc !== 32'd0) begin
            errors++;
            $display("FAIL rst_isr got flags=%b rpc=%h epc=%h want 0000 0 0",
                     {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie}, bus.O_redirect_pc, bus.O_epc);
        end
        step();
        bus.I_reti = 1'b0;
        checks++;
        if (bus.O_redirect !== 1'b0) begin
            errors++;
            $display("FAIL rst_isr_reti got redirect=%b want 0", bus.O_redirect);
        end
    endtask

    // Randomized traffic checked against a rule-level model: a handler flag,
    // a "request accepted, awaiting safe point" flag and saved addresses.
    task automatic test_random();
        bit          m_ie, m_handler, m_waiting, e_ack, e_red;
        logic [1:0]  m_vec;
        logic [31:0] m_epc, m_rpc;
        quiet();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ie = 0; m_handler = 0; m_waiting = 0; m_vec = 2'd0; m_epc = 32'd0; m_rpc = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) bus.I_intr = ~bus.I_intr;
            bus.I_intr_vector    = 2'($urandom);
            bus.I_pc             = $urandom;
            bus.I_stall          = ($urandom_range(0, 2) == 0);
            bus.I_branch_pending = ($urandom_range(0, 4) == 0);
            bus.I_reti           = ($urandom_range(0, 5) == 0);
            bus.I_ie_set         = ($urandom_range(0, 5) == 0);
            bus.I_ie_clr         = ($urandom_range(0, 19) == 0);
            rst                  = ($urandom_range(0, 149) == 0);

            e_ack = 0; e_red = 0;
            if (rst) begin
                m_ie = 0; m_handler = 0; m_waiting = 0; m_epc = 32'd0; m_rpc = 32'd0;
            end else begin
                if (m_handler) begin
                    if (bus.I_reti) begin
                        e_red = 1; m_rpc = m_epc; m_handler = 0;
                    end
                end else if (m_waiting) begin
                    if (!bus.I_intr || !m_ie) begin
                        m_waiting = 0;
                    end else if (!bus.I_stall && !bus.I_branch_pending) begin
                        e_ack = 1; e_red = 1;
                        m_rpc = BASE + 32'(m_vec) * (32'd1 << SHIFT);
                        m_epc = bus.I_pc; m_handler = 1; m_waiting = 0;
                    end
                end else if (bus.I_intr && m_ie) begin
                    if (bus.I_intr_vector == 2'd0) e_ack = 1;
                    else begin
                        m_waiting = 1; m_vec = bus.I_intr_vector;
                    end
                end
                if (bus.I_ie_clr) m_ie = 0;
                else if (bus.I_ie_set) m_ie = 1;
            end

            step();
            checks++;
            if ({bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie} !== {e_ack, e_red, m_handler, m_ie} ||
                bus.O_epc !== m_epc || (e_red && bus.O_redirect_pc !== m_rpc)) begin
                errors++;
                $display("FAIL random[%0d] got flags=%b rpc=%h epc=%h want %b %h %h", c,
                         {bus.O_intr_ack, bus.O_redirect, bus.O_in_isr, bus.O_ie}, bus.O_redirect_pc,
                         bus.O_epc, {e_ack, e_red, m_handler, m_ie}, m_rpc, m_epc);
            end
        end
        rst = 1'b0;
        quiet();
    endtask

    initial begin
        rst = 1'b1;
        bus.I_pc = 32'd0;
        quiet();
        test_reset();
        test_dispatch();
        test_stall();
        test_no_nesting();
        test_wait_abort();
        test_ie_disabled();
        test_spurious();
        test_reset_in_isr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
